btb_update_ctrl: RTL and testbench

- Produces the branch-resolution update stream that the BTB consumes.
- Keeps an in-order queue of front-end predictions made at fetch.
- Matches each execute-stage branch resolution against the oldest queued prediction.
- Emits the BTB write/delete update and a front-end redirect on misprediction.

---
 rtl/btb_update_ctrl.sv | 170 +++++++++++++++++
 tb/tb_btb_update_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: in-order queue of fetch-time branch predictions.
// Each execute-stage resolution is compared against the oldest queued
// prediction. The result is a registered BTB write/delete update and a
// front-end redirect on a misprediction.
module btb_update_ctrl #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 4,
  parameter int ILEN_BYTES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       pred_valid_i,
  output logic                       pred_ready_o,
  input  logic [XLEN-1:0]            pred_pc_i,
  input  logic                       pred_taken_i,
  input  logic [XLEN-1:0]            pred_target_i,
  input  logic                       res_valid_i,
  output logic                       res_ready_o,
  input  logic [XLEN-1:0]            res_pc_i,
  input  logic                       res_taken_i,
  input  logic [XLEN-1:0]            res_target_i,
  output logic                       update_valid_o,
  output logic                       del_entry_o,
  output logic [XLEN-1:0]            res_pc_o,
  output logic [XLEN-1:0]            res_target_o,
  output logic                       mispredict_o,
  output logic [XLEN-1:0]            redirect_pc_o,
  output logic                       pc_mismatch_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc_q     [DEPTH];
  logic [XLEN-1:0] pc_d     [DEPTH];
  logic [XLEN-1:0] target_q [DEPTH];
  logic [XLEN-1:0] target_d [DEPTH];
  logic [DEPTH-1:0] taken_q, taken_d;

  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            update_valid_q, update_valid_d;
  logic            del_entry_q, del_entry_d;
  logic [XLEN-1:0] res_pc_q, res_pc_d;
  logic [XLEN-1:0] res_target_q, res_target_d;
  logic            mispredict_q, mispredict_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            pc_mismatch_q, pc_mismatch_d;

  logic            push, pop;
  logic [XLEN-1:0] h_pc, h_target, fall;
  logic            h_taken;
  logic            wrong_t, wrong_nt, wrong;

  // Handshakes depend only on registered occupancy, so a same-cycle pop
  // never opens room for a push.
  assign pred_ready_o = (count_q < CW'(DEPTH));
  assign res_ready_o  = (count_q != '0);

  assign update_valid_o = update_valid_q;
  assign del_entry_o    = del_entry_q;
  assign res_pc_o       = res_pc_q;
  assign res_target_o   = res_target_q;
  assign mispredict_o   = mispredict_q;
  assign redirect_pc_o  = redirect_pc_q;
  assign pc_mismatch_o  = pc_mismatch_q;
  assign count_o        = count_q;

  // Classify the resolution against the head entry.
  always_comb begin
    push     = pred_valid_i & pred_ready_o;
    pop      = res_valid_i & res_ready_o;
    h_pc     = pc_q[rd_ptr_q];
    h_target = target_q[rd_ptr_q];
    h_taken  = taken_q[rd_ptr_q];
    fall     = res_pc_i + XLEN'(ILEN_BYTES);
    wrong_t  = res_taken_i & (~h_taken | (h_target != res_target_i));
    wrong_nt = ~res_taken_i & h_taken;
    wrong    = wrong_t | wrong_nt;
  end

  // Next-state for the queue and the registered update/redirect outputs.
  always_comb begin
    pc_d           = pc_q;
    target_d       = target_q;
    taken_d        = taken_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    update_valid_d = 1'b0;
    del_entry_d    = 1'b0;
    mispredict_d   = 1'b0;
    pc_mismatch_d  = 1'b0;
    res_pc_d       = res_pc_q;
    res_target_d   = res_target_q;
    redirect_pc_d  = redirect_pc_q;

    if (flush_i) begin
      // Flush wins over everything; a resolution in this cycle is dropped.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (pop && wrong) begin
      // Everything behind the head is wrong-path: squash, including a
      // same-cycle push.
      pc_mismatch_d  = (res_pc_i != h_pc);
      update_valid_d = 1'b1;
      mispredict_d   = 1'b1;
      res_pc_d       = res_pc_i;
      del_entry_d    = wrong_nt;
      res_target_d   = wrong_nt ? '0 : res_target_i;
      redirect_pc_d  = wrong_nt ? fall : res_target_i;
      rd_ptr_d       = '0;
      wr_ptr_d       = '0;
      count_d        = '0;
    end else begin
      if (pop) begin
        pc_mismatch_d = (res_pc_i != h_pc);
        rd_ptr_d      = rd_ptr_q + 1'b1;
      end
      if (push) begin
        pc_d[wr_ptr_q]     = pred_pc_i;
        target_d[wr_ptr_q] = pred_target_i;
        taken_d[wr_ptr_q]  = pred_taken_i;
        wr_ptr_d           = wr_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // State registers; reset empties the queue and clears all outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]     <= '0;
        target_q[i] <= '0;
      end
      taken_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      update_valid_q <= 1'b0;
      del_entry_q    <= 1'b0;
      res_pc_q       <= '0;
      res_target_q   <= '0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= '0;
      pc_mismatch_q  <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      target_q       <= target_d;
      taken_q        <= taken_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      update_valid_q <= update_valid_d;
      del_entry_q    <= del_entry_d;
      res_pc_q       <= res_pc_d;
      res_target_q   <= res_target_d;
      mispredict_q   <= mispredict_d;
      redirect_pc_q  <= redirect_pc_d;
      pc_mismatch_q  <= pc_mismatch_d;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: a reference queue model predicts the
// registered outputs for each driven cycle; results are compared 1 cycle later.
module tb_btb_update_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i;
  logic        pred_valid_i;
  logic        pred_ready_o;
  logic [31:0] pred_pc_i;
  logic        pred_taken_i;
  logic [31:0] pred_target_i;
  logic        res_valid_i;
  logic        res_ready_o;
  logic [31:0] res_pc_i;
  logic        res_taken_i;
  logic [31:0] res_target_i;
  logic        update_valid_o;
  logic        del_entry_o;
  logic [31:0] res_pc_o;
  logic [31:0] res_target_o;
  logic        mispredict_o;
  logic [31:0] redirect_pc_o;
  logic        pc_mismatch_o;
  logic [2:0]  count_o;

  btb_update_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o),
    .pred_pc_i(pred_pc_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o),
    .res_pc_i(res_pc_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
    .update_valid_o(update_valid_o), .del_entry_o(del_entry_o),
    .res_pc_o(res_pc_o), .res_target_o(res_target_o),
    .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
    .pc_mismatch_o(pc_mismatch_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } pred_t;

  typedef struct {
    logic        uv;
    logic        del;
    logic        mp;
    logic        pm;
    logic [31:0] rpc;
    logic [31:0] rtg;
    logic [31:0] rdr;
    int          cnt;
  } exp_t;

  pred_t mq[$];
  exp_t  sb[$];
  logic [31:0] m_rpc, m_rtg, m_rdr;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, predict its outcome, then compare one edge later.
  task automatic step(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
                      input logic rv, input logic [31:0] rpc, input logic rt, input logic [31:0] rtg,
                      input logic fl);
    exp_t  e;
    pred_t h, p;
    logic  rp, rr, push, pop, wr;
    @(negedge clk_i);
    pred_valid_i = pv; pred_pc_i = ppc; pred_taken_i = pt; pred_target_i = ptg;
    res_valid_i = rv; res_pc_i = rpc; res_taken_i = rt; res_target_i = rtg;
    flush_i = fl;
    rp = (mq.size() < 4);
    rr = (mq.size() != 0);
    #1;
    check_val("pred_ready", pred_ready_o, rp);
    check_val("res_ready", res_ready_o, rr);
    push = pv & rp;
    pop  = rv & rr;
    e.uv = 0; e.del = 0; e.mp = 0; e.pm = 0;
    if (fl) begin
      mq.delete();
    end else begin
      wr = 0;
      if (pop) begin
        h = mq[0];
        e.pm = (rpc != h.pc);
        if (rt && (!h.taken || h.target != rtg)) begin
          wr = 1; e.del = 0; m_rpc = rpc; m_rtg = rtg; m_rdr = rtg;
        end else if (!rt && h.taken) begin
          wr = 1; e.del = 1; m_rpc = rpc; m_rtg = 32'h0; m_rdr = rpc + 32'd4;
        end
        e.uv = wr; e.mp = wr;
        if (wr) mq.delete();
        else void'(mq.pop_front());
      end
      if (push && !wr) begin
        p.pc = ppc; p.taken = pt; p.target = ptg;
        mq.push_back(p);
      end
    end
    e.rpc = m_rpc; e.rtg = m_rtg; e.rdr = m_rdr; e.cnt = mq.size();
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check_val("update_valid", update_valid_o, e.uv);
    check_val("mispredict", mispredict_o, e.mp);
    check_val("pc_mismatch", pc_mismatch_o, e.pm);
    check_val("count", count_o, e.cnt);
    if (e.uv) check_val("del_entry", del_entry_o, e.del);
    check_val("res_pc", res_pc_o, e.rpc);
    check_val("res_target", res_target_o, e.rtg);
    check_val("redirect_pc", redirect_pc_o, e.rdr);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] rp;
    rst_n_i = 0; flush_i = 0; pred_valid_i = 0; pred_pc_i = 0; pred_taken_i = 0;
    pred_target_i = 0; res_valid_i = 0; res_pc_i = 0; res_taken_i = 0; res_target_i = 0;
    m_rpc = 0; m_rtg = 0; m_rdr = 0;
    #12;
    check_val("rst_pred_ready", pred_ready_o, 1);
    check_val("rst_res_ready", res_ready_o, 0);
    check_val("rst_count", count_o, 0);
    check_val("rst_strobes", {update_valid_o, mispredict_o, pc_mismatch_o, del_entry_o}, 0);
    check_val("rst_data", {res_pc_o, res_target_o}, 0);
    @(negedge clk_i);
    rst_n_i = 1;

    // Correct taken prediction
    step(1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h100, 1, 32'h200, 0);
    idle();
    // Predicted not-taken, actually taken
    step(1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h104, 1, 32'h300, 0);
    idle();
    // Predicted taken, actually not-taken, younger entries squashed
    step(1, 32'h108, 1, 32'h400, 0, 0, 0, 0, 0);
    step(1, 32'h10C, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h110, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h114, 0, 0, 1, 32'h108, 0, 0, 0);
    idle();
    // Fill, then push and pop together while full
    step(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h108, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h10C, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h120, 0, 0, 1, 32'h100, 0, 0, 0);
    // PC mismatch on an otherwise correct resolution
    step(0, 0, 0, 0, 1, 32'h500, 0, 0, 0);
    idle();
    // Flush with pending entries, same-cycle mispredicting resolution and push
    step(1, 32'h130, 0, 0, 1, 32'h108, 1, 32'h700, 1);
    idle();
    // Empty queue: resolution not consumed
    step(0, 0, 0, 0, 1, 32'h108, 1, 32'h700, 0);
    // Wrap-around target at top of address space
    step(1, 32'hFFFF_FFFC, 1, 32'h40, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rp = (mq.size() != 0 && $urandom_range(0, 7) != 0) ? mq[0].pc : 32'h800;
      step($urandom_range(0, 1), 32'h1000 + 32'($urandom_range(0, 15) * 4), 1'($urandom_range(0, 1)), 32'h200,
           1'($urandom_range(0, 2) == 0), rp, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 32'h300 : 32'h200, 1'($urandom_range(0, 20) == 0));
    end

    // Asynchronous reset right after a strobe
    step(1, 32'h900, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h900, 1, 32'h950, 0);
    rst_n_i = 0;
    #1;
    check_val("arst_strobes", {update_valid_o, mispredict_o, pc_mismatch_o}, 0);
    check_val("arst_count", count_o, 0);
    check_val("arst_data", {res_pc_o, redirect_pc_o}, 0);
    mq.delete(); m_rpc = 0; m_rtg = 0; m_rdr = 0;
    @(negedge clk_i);
    rst_n_i = 1;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
